// File: rtl/fp_div.sv
// fp_div: iterative IEEE-754 single-precision divider, out_result = in_a / in_b.
//   A restoring radix-2 mantissa divider produces one quotient bit per cycle.
//   Results are truncated, denormal inputs are flushed to zero, and results
//   that underflow are flushed to zero.
//
// Ports:
//   clk, rst_n            clock (rising edge) and synchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only when idle
//   in_a, in_b            dividend and divisor, captured on the accepting edge
//   out_valid / out_ready result handshake; the result is held until taken
//   out_result            quotient; keeps its last value while out_valid is low
//
// Latency from the accepting edge: 1 cycle for special operands,
// 27 cycles on the normal path (25 divide steps + 1 normalise + DONE).
module fp_div #(
    parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t             state_q,  state_d;
    logic [24:0]        rem_q,    rem_d;     // partial remainder, < 2*mb
    logic [23:0]        mb_q,     mb_d;      // divisor mantissa with hidden 1
    logic [24:0]        quo_q,    quo_d;     // quotient, quo[24] has weight 2^0
    logic signed [9:0]  exp_q,    exp_d;     // biased exponent before normalise
    logic [4:0]         cnt_q,    cnt_d;     // divide step counter, 0..24
    logic               sign_q,   sign_d;
    logic [31:0]        result_q, result_d;

    // Operand classification on the raw inputs
    logic        a_zero, b_zero, a_inf_nan, b_inf_nan, in_sign;
    logic [7:0]  exp_a, exp_b;

    assign exp_a     = in_a[30:23];
    assign exp_b     = in_b[30:23];
    assign a_zero    = (exp_a == 8'h00);
    assign b_zero    = (exp_b == 8'h00);
    assign a_inf_nan = (exp_a == 8'hFF);
    assign b_inf_nan = (exp_b == 8'hFF);
    assign in_sign   = in_a[31] ^ in_b[31];

    // One restoring step: subtract when the remainder covers the divisor
    logic        step_ge;
    logic [23:0] step_rem;

    assign step_ge  = (rem_q >= {1'b0, mb_q});
    // After a restoring step the remainder is below mb, so bit 24 is always 0
    assign step_rem = step_ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];

    // Normalisation: the quotient lies in (0.5, 2), so at most a 1-bit shift
    logic signed [9:0] norm_exp;
    logic [22:0]       norm_frac;

    assign norm_exp  = quo_q[24] ? exp_q : exp_q - 10'sd1;
    assign norm_frac = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case leaves a latch.
        state_d  = state_q;
        rem_d    = rem_q;
        mb_d     = mb_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    if (a_inf_nan || b_inf_nan || (a_zero && b_zero)) begin
                        result_d = NAN_PATTERN;
                        state_d  = DONE;
                    end else if (b_zero) begin
                        result_d = {in_sign, 8'hFF, 23'h0};
                        state_d  = DONE;
                    end else if (a_zero) begin
                        result_d = {in_sign, 31'h0};
                        state_d  = DONE;
                    end else begin
                        rem_d   = {2'b01, in_a[22:0]};
                        mb_d    = {1'b1, in_b[22:0]};
                        quo_d   = '0;
                        cnt_d   = '0;
                        exp_d   = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = {step_rem, 1'b0};
                quo_d = {quo_q[23:0], step_ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (norm_exp >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                end else if (norm_exp <= 10'sd0) begin
                    result_d = {sign_q, 31'h0};
                end else begin
                    result_d = {sign_q, norm_exp[7:0], norm_frac};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            mb_q     <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            mb_q     <= mb_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;

endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: directed, table-driven check of fp_div, plus hand-written
// sequences for backpressure and mid-operation reset.
module tb_fp_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int checks;
    int failures;

    fp_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Presents one operand pair, waits (bounded) for acceptance and for the
    // result. lat counts edges from the accepting edge to the first edge at
    // which out_valid is high; -1 if the result never arrives.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy_seen);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = 32'hDEADBEEF;
        in_b      = 32'h12345678;
        busy_seen = !in_ready;
        lat       = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = out_result;
        if (!out_valid) lat = -1;
    endtask

    vec_t        vecs[11];
    logic [31:0] res;
    int          lat;
    logic        busy;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        vecs[0]  = '{"six_div_two",   32'h40C00000, 32'h40000000, 32'h40400000, 27};
        vecs[1]  = '{"one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27};
        vecs[2]  = '{"neg_1p5_div_half", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 27};
        vecs[3]  = '{"neg_div_zero",  32'hBF800000, 32'h00000000, 32'hFF800000, 1};
        vecs[4]  = '{"zero_div_five", 32'h00000000, 32'h40A00000, 32'h00000000, 1};
        vecs[5]  = '{"zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1};
        vecs[6]  = '{"inf_div_one",   32'h7F800000, 32'h3F800000, 32'h7FC00000, 1};
        vecs[7]  = '{"denorm_div_one", 32'h00000001, 32'h3F800000, 32'h00000000, 1};
        vecs[8]  = '{"overflow",      32'h7F000000, 32'h3E800000, 32'h7F800000, 27};
        vecs[9]  = '{"underflow",     32'h00800000, 32'h40000000, 32'h00000000, 27};
        vecs[10] = '{"one_div_nan",   32'h3F800000, 32'h7FC12345, 32'h7FC00000, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_out_valid",  {31'h0, out_valid}, 32'h0);
        check("reset_in_ready",   {31'h0, in_ready},  32'h1);
        check("reset_out_result", out_result,         32'h0);

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].a, vecs[i].b, res, lat, busy);
            check({vecs[i].name, "_result"}, res, vecs[i].exp_res);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].exp_lat > 1)
                check({vecs[i].name, "_busy"}, {31'h0, busy}, 32'h1);
            // out_ready is high, so the result is taken at the next edge
            @(negedge clk);
            check({vecs[i].name, "_drop_valid"}, {31'h0, out_valid}, 32'h0);
            check({vecs[i].name, "_idle_ready"}, {31'h0, in_ready},  32'h1);
        end

        // Backpressure: hold the result for 10 cycles while a second
        // operand pair is offered and must be ignored.
        out_ready = 1'b0;
        do_op(32'h3F800000, 32'h40400000, res, lat, busy);
        check("bp_result", res, 32'h3EAAAAAA);
        in_valid = 1'b1;
        in_a     = 32'h40C00000;
        in_b     = 32'h40000000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid",  {31'h0, out_valid}, 32'h1);
            check("bp_hold_result", out_result,         32'h3EAAAAAA);
            check("bp_hold_ready",  {31'h0, in_ready},  32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid",  {31'h0, out_valid}, 32'h0);
        check("bp_release_ready",  {31'h0, in_ready},  32'h1);
        check("bp_release_result", out_result,         32'h3EAAAAAA);
        do_op(32'h40C00000, 32'h40000000, res, lat, busy);
        check("bp_next_result",  res,      32'h40400000);
        check("bp_next_latency", 32'(lat), 32'd27);
        @(negedge clk);

        // Reset in the middle of the divide loop
        in_valid = 1'b1;
        in_a     = 32'h3F800000;
        in_b     = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy", {31'h0, in_ready}, 32'h0);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_reset_valid",  {31'h0, out_valid}, 32'h0);
        check("mid_reset_result", out_result,         32'h0);
        check("mid_reset_ready",  {31'h0, in_ready},  32'h1);
        // No stray result may appear after the abandoned operation
        repeat (30) begin
            @(negedge clk);
            check("mid_reset_no_result", {31'h0, out_valid}, 32'h0);
        end
        do_op(32'h40C00000, 32'h40000000, res, lat, busy);
        check("post_reset_result",  res,      32'h40400000);
        check("post_reset_latency", 32'(lat), 32'd27);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
